// File: rtl/main_memory_ctrl.sv
// Behavioural main memory and controller behind the L1 data cache.
// It serves 8-word line fills through the word-index echo handshake.
// It accepts single-word write-through stores.
// A programmable latency runs between request capture and the first data word or the store commit.
module main_memory_ctrl #(
    parameter int unsigned MEM_WORDS      = 1024,
    parameter int unsigned WORDS_PER_LINE = 8,
    parameter int unsigned LATENCY        = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        VALID,
    output logic        READY,
    input  logic        LOAD,
    input  logic        STORE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic [3:0]  ACK_DATA_MEM,
    input  logic [3:0]  ACK_DATA_L1,
    output logic        DONE
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned OW = $clog2(WORDS_PER_LINE);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LAT      = 3'd1;
    localparam logic [2:0] S_BURST    = 3'd2;
    localparam logic [2:0] S_STCOMMIT = 3'd3;
    localparam logic [2:0] S_RELEASE  = 3'd4;

    localparam logic [3:0]    ACK_NONE = 4'b1111;
    localparam logic [3:0]    LAT_LAST = 4'(LATENCY - 1);
    localparam logic [OW-1:0] K_LAST   = OW'(WORDS_PER_LINE - 1);

    logic [2:0]    state;
    logic          is_load;
    logic [AW-1:0] line_addr;
    logic [31:0]   wdata_q;
    logic [3:0]    lat_cnt;
    logic [OW-1:0] k;

    logic [OW-1:0] k_next;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_data;
    logic          mem_we;
    logic          addr_unused;

    // Each entry stores its data XORed with its own index.
    // An all-zero power-up array therefore reads back as mem[i] = i.
    logic [31:0] mem_q [MEM_WORDS];

    assign addr_unused = ^ADDR[31:AW];

    // Read index: line base in LAT, next word of the line during a burst; commit strobe for stores
    always_comb begin
        k_next  = k + OW'(1);
        rd_idx  = line_addr;
        if (state == S_BURST) begin
            rd_idx = line_addr | AW'(k_next);
        end
        rd_data = mem_q[rd_idx] ^ 32'(rd_idx);
        mem_we  = (state == S_LAT) && (lat_cnt == LAT_LAST) && VALID && !is_load;
    end

    // Memory write port; storage is deliberately not reset
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[line_addr] <= wdata_q ^ 32'(line_addr);
        end
    end

    // Transaction state machine and registered outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= S_IDLE;
            READY        <= 1'b0;
            RDATA        <= '0;
            ACK_DATA_MEM <= ACK_NONE;
            DONE         <= 1'b0;
            is_load      <= 1'b0;
            line_addr    <= '0;
            wdata_q      <= '0;
            lat_cnt      <= '0;
            k            <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    READY   <= 1'b1;
                    lat_cnt <= '0;
                    k       <= '0;
                    if (READY && VALID && LOAD) begin
                        READY     <= 1'b0;
                        is_load   <= 1'b1;
                        line_addr <= {ADDR[AW-1:OW], {OW{1'b0}}};
                        state     <= S_LAT;
                    end else if (READY && VALID && STORE) begin
                        READY     <= 1'b0;
                        is_load   <= 1'b0;
                        line_addr <= ADDR[AW-1:0];
                        wdata_q   <= WDATA;
                        state     <= S_LAT;
                    end
                end
                S_LAT: begin
                    if (!VALID) begin
                        READY        <= 1'b1;
                        ACK_DATA_MEM <= ACK_NONE;
                        state        <= S_IDLE;
                    end else if (lat_cnt == LAT_LAST) begin
                        ACK_DATA_MEM <= 4'd0;
                        if (is_load) begin
                            RDATA <= rd_data;
                            state <= S_BURST;
                        end else begin
                            state <= S_STCOMMIT;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                S_BURST: begin
                    if (!VALID) begin
                        READY        <= 1'b1;
                        ACK_DATA_MEM <= ACK_NONE;
                        state        <= S_IDLE;
                    end else if (ACK_DATA_L1 == ACK_DATA_MEM) begin
                        if (k == K_LAST) begin
                            ACK_DATA_MEM <= ACK_NONE;
                            DONE         <= 1'b1;
                            state        <= S_RELEASE;
                        end else begin
                            k            <= k_next;
                            RDATA        <= rd_data;
                            ACK_DATA_MEM <= ACK_DATA_MEM + 4'd1;
                        end
                    end
                end
                S_STCOMMIT: begin
                    DONE         <= 1'b1;
                    ACK_DATA_MEM <= ACK_NONE;
                    state        <= S_RELEASE;
                end
                S_RELEASE: begin
                    DONE <= 1'b0;
                    if (!VALID) begin
                        READY <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl: vector table of L1 transactions,
// a reference memory model and a scoreboard of expected fill words.
module tb_main_memory_ctrl;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned NVEC    = 15;

    logic        CLK;
    logic        RESET_N;
    logic        VALID;
    logic        READY;
    logic        LOAD;
    logic        STORE;
    logic [31:0] ADDR;
    logic [31:0] WDATA;
    logic [31:0] RDATA;
    logic [3:0]  ACK_DATA_MEM;
    logic [3:0]  ACK_DATA_L1;
    logic        DONE;

    main_memory_ctrl #(
        .MEM_WORDS(1024),
        .WORDS_PER_LINE(8),
        .LATENCY(LATENCY)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .VALID(VALID),
        .READY(READY),
        .LOAD(LOAD),
        .STORE(STORE),
        .ADDR(ADDR),
        .WDATA(WDATA),
        .RDATA(RDATA),
        .ACK_DATA_MEM(ACK_DATA_MEM),
        .ACK_DATA_L1(ACK_DATA_L1),
        .DONE(DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // act: 0 none, 1 abort (load: at word act_k; store: at LAT cycle act_k), 2 reset at word act_k
    typedef struct {
        bit          ld;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall_k;
        int          stall_n;
        int          act;
        int          act_k;
        logic [31:0] exp_w0;
        bit          exp_done;
    } vec_t;

    typedef struct {
        logic [3:0]  ack;
        logic [31:0] data;
        bit          ld;
    } exp_t;

    vec_t        vecs [NVEC];
    exp_t        sb [$];
    logic [31:0] model [1024];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int          cyc;
        int          stall_left;
        bit          fin;
        bit          first;
        logic [3:0]  last_ack;
        logic [3:0]  cur_ack;
        logic [31:0] cur_data;
        logic [9:0]  base;
        exp_t        e;

        cyc = 0;
        while (READY !== 1'b1 && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        check($sformatf("v%0d_ready_before_req", vi), 32'(READY), 32'd1);

        ACK_DATA_L1 = 4'hF;
        VALID = 1'b1;
        LOAD  = v.ld;
        STORE = !v.ld;
        ADDR  = v.addr;
        WDATA = v.wdata;
        base  = {v.addr[9:3], 3'b000};
        if (v.ld) begin
            for (int w = 0; w < 8; w++) begin
                e.ack  = 4'(w);
                e.data = model[base | 10'(w)];
                e.ld   = 1'b1;
                sb.push_back(e);
            end
        end else begin
            e.ack  = 4'd0;
            e.data = 32'h0;
            e.ld   = 1'b0;
            sb.push_back(e);
        end

        cyc        = 0;
        stall_left = v.stall_n;
        fin        = 1'b0;
        first      = 1'b1;
        last_ack   = 4'hF;
        cur_ack    = 4'hF;
        cur_data   = 32'h0;
        while (!fin && cyc < 300) begin
            @(negedge CLK);
            cyc++;
            ACK_DATA_L1 = 4'hF;
            if (v.act == 1 && !v.ld && cyc == v.act_k) begin
                VALID = 1'b0;
                STORE = 1'b0;
                @(negedge CLK);
                check($sformatf("v%0d_abort_ack", vi), 32'(ACK_DATA_MEM), 32'hF);
                check($sformatf("v%0d_abort_done", vi), 32'(DONE), 32'd0);
                check($sformatf("v%0d_abort_ready", vi), 32'(READY), 32'd1);
                sb.delete();
                fin = 1'b1;
            end else if (DONE) begin
                check($sformatf("v%0d_done_expected", vi), 32'(DONE), 32'(v.exp_done));
                check($sformatf("v%0d_done_no_ready", vi), 32'(READY), 32'd0);
                check($sformatf("v%0d_done_ack_none", vi), 32'(ACK_DATA_MEM), 32'hF);
                check($sformatf("v%0d_sb_empty", vi), 32'(sb.size()), 32'd0);
                if (!v.ld) model[v.addr[9:0]] = v.wdata;
                @(negedge CLK);
                check($sformatf("v%0d_release_hold", vi), 32'(READY), 32'd0);
                check($sformatf("v%0d_done_pulse", vi), 32'(DONE), 32'd0);
                VALID = 1'b0;
                LOAD  = 1'b0;
                STORE = 1'b0;
                @(negedge CLK);
                check($sformatf("v%0d_release_ready", vi), 32'(READY), 32'd1);
                fin = 1'b1;
            end else if (ACK_DATA_MEM != 4'hF) begin
                if (ACK_DATA_MEM != last_ack) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL v%0d_extra_word: got ack %0d, expected no word", vi, ACK_DATA_MEM);
                    end else begin
                        e = sb.pop_front();
                        cur_ack  = e.ack;
                        cur_data = e.data;
                        check($sformatf("v%0d_ack_idx", vi), 32'(ACK_DATA_MEM), 32'(e.ack));
                        if (e.ld) check($sformatf("v%0d_rdata_w%0d", vi, e.ack), RDATA, e.data);
                        if (first) begin
                            check($sformatf("v%0d_latency", vi), 32'(cyc), 32'(LATENCY + 1));
                            if (v.ld) check($sformatf("v%0d_word0", vi), RDATA, v.exp_w0);
                            first = 1'b0;
                        end
                    end
                    last_ack = ACK_DATA_MEM;
                end else if (v.ld) begin
                    check($sformatf("v%0d_held_w%0d", vi, cur_ack), RDATA, cur_data);
                end

                if (v.ld && v.act == 1 && int'(cur_ack) == v.act_k) begin
                    VALID = 1'b0;
                    LOAD  = 1'b0;
                    @(negedge CLK);
                    check($sformatf("v%0d_abort_ack", vi), 32'(ACK_DATA_MEM), 32'hF);
                    check($sformatf("v%0d_abort_done", vi), 32'(DONE), 32'd0);
                    check($sformatf("v%0d_abort_ready", vi), 32'(READY), 32'd1);
                    sb.delete();
                    fin = 1'b1;
                end else if (v.ld && v.act == 2 && int'(cur_ack) == v.act_k) begin
                    RESET_N = 1'b0;
                    VALID   = 1'b0;
                    LOAD    = 1'b0;
                    #1;
                    check($sformatf("v%0d_rst_ready", vi), 32'(READY), 32'd0);
                    check($sformatf("v%0d_rst_ack", vi), 32'(ACK_DATA_MEM), 32'hF);
                    check($sformatf("v%0d_rst_done", vi), 32'(DONE), 32'd0);
                    check($sformatf("v%0d_rst_rdata", vi), RDATA, 32'h0);
                    @(negedge CLK);
                    RESET_N = 1'b1;
                    @(negedge CLK);
                    check($sformatf("v%0d_rst_ready_rise", vi), 32'(READY), 32'd1);
                    sb.delete();
                    fin = 1'b1;
                end else if (v.ld) begin
                    if (int'(cur_ack) == v.stall_k && stall_left > 0) begin
                        stall_left--;
                    end else begin
                        ACK_DATA_L1 = cur_ack;
                    end
                end
            end
        end
        if (!fin) begin
            n_cmp++;
            n_err++;
            $display("FAIL v%0d_timeout: got no completion within 300 cycles, expected DONE or abort", vi);
            VALID = 1'b0;
            LOAD  = 1'b0;
            STORE = 1'b0;
            sb.delete();
            repeat (3) @(negedge CLK);
        end
        ACK_DATA_L1 = 4'hF;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = 32'(i);

        //          ld    addr          wdata         stk stn act ak exp_w0        done
        vecs[0]  = '{1'b1, 32'h0000_002B, 32'h0,        -1, 0, 0, 0, 32'h0000_0028, 1'b1};
        vecs[1]  = '{1'b1, 32'h0000_002B, 32'h0,         3, 5, 0, 0, 32'h0000_0028, 1'b1};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'hDEADBEEF, -1, 0, 0, 0, 32'h0,         1'b1};
        vecs[3]  = '{1'b1, 32'h0000_0013, 32'h0,        -1, 0, 0, 0, 32'hDEADBEEF,  1'b1};
        vecs[4]  = '{1'b1, 32'h0000_040F, 32'h0,        -1, 0, 0, 0, 32'h0000_0008, 1'b1};
        vecs[5]  = '{1'b1, 32'h0000_03FF, 32'h0,         7, 2, 0, 0, 32'h0000_03F8, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0020, 32'h0,        -1, 0, 1, 2, 32'h0000_0020, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0055, 32'hBAD0BAD0, -1, 0, 1, 2, 32'h0,         1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0050, 32'h0,        -1, 0, 0, 0, 32'h0000_0050, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0100, 32'h0,        -1, 0, 2, 5, 32'h0000_0100, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0100, 32'h0,        -1, 0, 0, 0, 32'h0000_0100, 1'b1};
        vecs[11] = '{1'b0, 32'h0000_03FF, 32'h12345678, -1, 0, 0, 0, 32'h0,         1'b1};
        vecs[12] = '{1'b1, 32'h0000_03F9, 32'h0,        -1, 0, 0, 0, 32'h0000_03F8, 1'b1};
        vecs[13] = '{1'b0, 32'h0000_0812, 32'hCAFEF00D, -1, 0, 0, 0, 32'h0,         1'b1};
        vecs[14] = '{1'b1, 32'h0000_0010, 32'h0,        -1, 0, 0, 0, 32'hDEADBEEF,  1'b1};

        RESET_N     = 1'b0;
        VALID       = 1'b0;
        LOAD        = 1'b0;
        STORE       = 1'b0;
        ADDR        = 32'h0;
        WDATA       = 32'h0;
        ACK_DATA_L1 = 4'hF;

        repeat (3) @(negedge CLK);
        check("reset_ready", 32'(READY), 32'd0);
        check("reset_ack", 32'(ACK_DATA_MEM), 32'hF);
        check("reset_done", 32'(DONE), 32'd0);
        check("reset_rdata", RDATA, 32'h0);
        RESET_N = 1'b1;
        @(negedge CLK);
        check("post_reset_ready", 32'(READY), 32'd1);
        check("post_reset_ack", 32'(ACK_DATA_MEM), 32'hF);
        check("post_reset_done", 32'(DONE), 32'd0);

        // LOAD/STORE without VALID, then VALID alone: both must be ignored
        LOAD  = 1'b1;
        STORE = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("novalid_ready", 32'(READY), 32'd1);
            check("novalid_ack", 32'(ACK_DATA_MEM), 32'hF);
        end
        LOAD  = 1'b0;
        STORE = 1'b0;
        VALID = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("validonly_ready", 32'(READY), 32'd1);
            check("validonly_ack", 32'(ACK_DATA_MEM), 32'hF);
        end
        VALID = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < int'(NVEC); i++) begin
            run_vec(vecs[i], i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
